cond_eval: RTL and testbench

COND_EVAL -- requirements
Module: cond_eval

---
 rtl/cond_eval_if.sv | 27 ++
 rtl/cond_eval.sv | 110 +++++++++++
 tb/tb_cond_eval.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/cond_eval_if.sv
// Handshake and flag bus for the condition evaluator: instruction in, result out,
// architectural flag write port and retirement statistics.
interface cond_eval_if;
  logic        flag_we;
  logic [3:0]  flag_in;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  cond;
  logic [3:0]  opcode;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode;
  logic        exec;
  logic [3:0]  flags;
  logic [15:0] exec_count;
  logic [15:0] skip_count;

  modport master (
    output flag_we, flag_in, in_valid, cond, opcode, out_ready,
    input  in_ready, out_valid, out_opcode, exec, flags, exec_count, skip_count
  );

  modport slave (
    input  flag_we, flag_in, in_valid, cond, opcode, out_ready,
    output in_ready, out_valid, out_opcode, exec, flags, exec_count, skip_count
  );
endinterface

// File: rtl/cond_eval.sv
// ARM-style condition evaluator: one-deep registered result stage with forwarded
// NZCV flags and saturating executed/squashed retirement counters.
module cond_eval (
  input  logic      clk,
  input  logic      reset,
  cond_eval_if.slave bus
);

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  localparam logic [3:0]  OPCODE_NOP = 4'b1111;
  localparam logic [15:0] COUNT_MAX  = 16'hFFFF;

  logic [3:0]  flags_q;
  logic        out_valid_q;
  logic        exec_q;
  logic [3:0]  opcode_q;
  logic [15:0] exec_count_q;
  logic [15:0] skip_count_q;

  logic [3:0]  eval_flags;
  logic        cond_true;
  logic        exec_next;
  logic        in_ready;
  logic        accept;
  logic        handshake;

  // A flag write in the accepting cycle is forwarded so the instruction sees it.
  assign eval_flags = bus.flag_we ? bus.flag_in : flags_q;

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    logic n, z, c, v;
    cond_true = 1'b0;
    {n, z, c, v} = eval_flags;
    case (cond_e'(bus.cond))
      COND_EQ: cond_true = z;
      COND_NE: cond_true = !z;
      COND_CS: cond_true = c;
      COND_CC: cond_true = !c;
      COND_MI: cond_true = n;
      COND_PL: cond_true = !n;
      COND_VS: cond_true = v;
      COND_VC: cond_true = !v;
      COND_HI: cond_true = c && !z;
      COND_LS: cond_true = !c || z;
      COND_GE: cond_true = (n == v);
      COND_LT: cond_true = (n != v);
      COND_GT: cond_true = !z && (n == v);
      COND_LE: cond_true = z || (n != v);
      COND_AL: cond_true = 1'b1;
      COND_NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

  assign exec_next = cond_true && (bus.opcode != OPCODE_NOP);

  assign in_ready  = reset && (!out_valid_q || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign handshake = out_valid_q && bus.out_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order within the block.
  // NOTE: reset is synchronous; a held result is simply dropped, never counted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_q      <= 4'b0000;
      out_valid_q  <= 1'b0;
      exec_q       <= 1'b0;
      opcode_q     <= OPCODE_NOP;
      exec_count_q <= 16'h0000;
      skip_count_q <= 16'h0000;
    end else begin
      if (bus.flag_we) flags_q <= bus.flag_in;

      if (accept) begin
        out_valid_q <= 1'b1;
        exec_q      <= exec_next;
        opcode_q    <= bus.opcode;
      end else if (handshake) begin
        out_valid_q <= 1'b0;
      end

      // Retirement statistics reflect the result leaving, not the one arriving.
      if (handshake && (opcode_q != OPCODE_NOP)) begin
        if (exec_q) begin
          if (exec_count_q != COUNT_MAX) exec_count_q <= exec_count_q + 16'd1;
        end else begin
          if (skip_count_q != COUNT_MAX) skip_count_q <= skip_count_q + 16'd1;
        end
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.exec       = exec_q;
  assign bus.out_opcode = opcode_q;
  assign bus.flags      = flags_q;
  assign bus.exec_count = exec_count_q;
  assign bus.skip_count = skip_count_q;

endmodule

// File: tb/tb_cond_eval.sv
// Directed bench for cond_eval: results are checked through a scoreboard filled at
// accept time from a reference condition table; counters follow a saturating model.
module tb_cond_eval;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cond_eval_if bus ();

  cond_eval dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       exec;
    logic [3:0] opcode;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [3:0]  m_flags = 4'h0;
  logic [15:0] m_exec_cnt = 16'h0;
  logic [15:0] m_skip_cnt = 16'h0;

  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return ~z;
      4'h2: return cy;
      4'h3: return ~cy;
      4'h4: return n;
      4'h5: return ~n;
      4'h6: return v;
      4'h7: return ~v;
      4'h8: return cy & ~z;
      4'h9: return ~cy | z;
      4'hA: return ~(n ^ v);
      4'hB: return n ^ v;
      4'hC: return ~z & ~(n ^ v);
      4'hD: return z | (n ^ v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: samples at the falling edge, mirroring what the next
  // rising edge will do (retire, accept, flag write).
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] fwd;
    if (!reset) begin
      check("in_ready_in_reset", 32'(bus.in_ready), 32'h0);
      sb.delete();
      m_flags    = 4'h0;
      m_exec_cnt = 16'h0;
      m_skip_cnt = 16'h0;
    end else begin
      check("out_valid_model", 32'(bus.out_valid), 32'(sb.size() != 0));
      check("in_ready_model", 32'(bus.in_ready), 32'((sb.size() == 0) || bus.out_ready));
      if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        check("out_exec", 32'(bus.exec), 32'(e.exec));
        check("out_opcode", 32'(bus.out_opcode), 32'(e.opcode));
        if (e.opcode != 4'hF) begin
          if (e.exec) begin
            if (m_exec_cnt != 16'hFFFF) m_exec_cnt = m_exec_cnt + 16'd1;
          end else begin
            if (m_skip_cnt != 16'hFFFF) m_skip_cnt = m_skip_cnt + 16'd1;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        fwd = bus.flag_we ? bus.flag_in : m_flags;
        e.exec   = ref_cond(bus.cond, fwd) && (bus.opcode != 4'hF);
        e.opcode = bus.opcode;
        sb.push_back(e);
      end
      if (bus.flag_we) m_flags = bus.flag_in;
    end
  end

  task automatic drive(input logic fwe, input logic [3:0] fin, input logic iv,
                       input logic [3:0] c, input logic [3:0] op, input logic ordy);
    bus.flag_we   = fwe;
    bus.flag_in   = fin;
    bus.in_valid  = iv;
    bus.cond      = c;
    bus.opcode    = op;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_exec_count"}, 32'(bus.exec_count), 32'(m_exec_cnt));
    check({tag, "_skip_count"}, 32'(bus.skip_count), 32'(m_skip_cnt));
  endtask

  initial begin
    logic [3:0]  pat [6];
    logic [15:0] save_e, save_s;
    pat = '{4'b0000, 4'b0100, 4'b0010, 4'b1001, 4'b1000, 4'b0110};

    // Reset with flag writes and instructions presented: all must be ignored.
    reset = 1'b0;
    drive(1'b1, 4'hF, 1'b1, 4'h0, 4'h0, 1'b1);
    drive(1'b1, 4'hF, 1'b1, 4'h0, 4'h0, 1'b1);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_exec", 32'(bus.exec), 32'h0);
    check("rst_out_opcode", 32'(bus.out_opcode), 32'hF);
    check("rst_flags", 32'(bus.flags), 32'h0);
    check("rst_exec_count", 32'(bus.exec_count), 32'h0);
    check("rst_skip_count", 32'(bus.skip_count), 32'h0);
    reset = 1'b1;

    // Flag write forwarded into an EQ evaluation in the same cycle.
    drive(1'b1, 4'b0100, 1'b1, 4'h0, 4'h0, 1'b0);
    check("fwd_out_valid", 32'(bus.out_valid), 32'h1);
    check("fwd_exec", 32'(bus.exec), 32'h1);
    check("fwd_flags", 32'(bus.flags), 32'h4);

    // Stall: flag write must not disturb the held exec; new input refused.
    drive(1'b1, 4'b0000, 1'b1, 4'h0, 4'h1, 1'b0);
    check("stall_exec", 32'(bus.exec), 32'h1);
    check("stall_opcode", 32'(bus.out_opcode), 32'h0);
    check("stall_flags", 32'(bus.flags), 32'h0);
    drive(1'b0, 4'h0, 1'b1, 4'h0, 4'h1, 1'b0);
    check("stall2_exec", 32'(bus.exec), 32'h1);
    idle();
    check("stall_release_valid", 32'(bus.out_valid), 32'h0);
    check("stall_release_exec_count", 32'(bus.exec_count), 32'h1);

    // GE then LT back-to-back with N=1,V=0 after a fresh reset.
    reset = 1'b0;
    idle();
    reset = 1'b1;
    drive(1'b1, 4'b1000, 1'b0, 4'h0, 4'h0, 1'b1);
    drive(1'b0, 4'h0, 1'b1, 4'hA, 4'h2, 1'b1);
    check("ge_exec", 32'(bus.exec), 32'h0);
    drive(1'b0, 4'h0, 1'b1, 4'hB, 4'h3, 1'b1);
    check("lt_exec", 32'(bus.exec), 32'h1);
    idle();
    check("gelt_skip_count", 32'(bus.skip_count), 32'h1);
    check("gelt_exec_count", 32'(bus.exec_count), 32'h1);

    // Full decode table under several flag patterns, with forwarding each cycle.
    foreach (pat[p]) begin
      for (int c = 0; c < 16; c++) begin
        drive(1'b1, pat[p], 1'b1, 4'(c), 4'(c + p) == 4'hF ? 4'h0 : 4'(c + p), 1'b1);
      end
    end
    idle();
    check_counts("table");

    // No-op with AL: squashed, counters untouched.
    save_e = m_exec_cnt;
    save_s = m_skip_cnt;
    drive(1'b0, 4'h0, 1'b1, 4'hE, 4'hF, 1'b1);
    check("nop_exec", 32'(bus.exec), 32'h0);
    check("nop_opcode", 32'(bus.out_opcode), 32'hF);
    idle();
    check("nop_exec_count", 32'(bus.exec_count), 32'(save_e));
    check("nop_skip_count", 32'(bus.skip_count), 32'(save_s));

    // Saturation: run exec_count up to FFFD, then past the ceiling.
    reset = 1'b0;
    idle();
    reset = 1'b1;
    for (int i = 0; i < 65533; i++) drive(1'b0, 4'h0, 1'b1, 4'hE, 4'h0, 1'b1);
    idle();
    check("sat_fffd", 32'(bus.exec_count), 32'hFFFD);
    for (int i = 0; i < 3; i++) drive(1'b0, 4'h0, 1'b1, 4'hE, 4'h0, 1'b1);
    idle();
    check("sat_ffff", 32'(bus.exec_count), 32'hFFFF);
    for (int i = 0; i < 2; i++) drive(1'b0, 4'h0, 1'b1, 4'hE, 4'h1, 1'b1);
    idle();
    check("sat_hold", 32'(bus.exec_count), 32'hFFFF);
    check_counts("sat");

    // Reset mid-stall discards the held result.
    drive(1'b1, 4'hA, 1'b1, 4'hE, 4'h2, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
    check("pre_rst_valid", 32'(bus.out_valid), 32'h1);
    reset = 1'b0;
    drive(1'b1, 4'hF, 1'b1, 4'hE, 4'h0, 1'b1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'h0);
    check("midrst_exec_count", 32'(bus.exec_count), 32'h0);
    check("midrst_skip_count", 32'(bus.skip_count), 32'h0);
    check("midrst_flags", 32'(bus.flags), 32'h0);
    check("midrst_out_opcode", 32'(bus.out_opcode), 32'hF);
    reset = 1'b1;
    idle();
    idle();
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
